// File: rtl/lsu_issue_arb.sv
// rtl/lsu_issue_arb.sv - LSU issue arbiter: store/load selection, one D-cache operation outstanding
// Optional feature: define LSU_ISSUE_ARB_PERF_EN to add perf_ld / perf_st / perf_flushed counters.
module lsu_issue_arb #(
  parameter int NUM_LD     = 8,
  parameter int ROB_W      = 5,
  parameter int PREG_W     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [ROB_W-1:0]              rob_head,
  input  logic [NUM_LD-1:0]             ld_rdy,
  input  logic [NUM_LD-1:0][31:0]       ld_addr,
  input  logic [NUM_LD-1:0][2:0]        ld_f3,
  input  logic [NUM_LD-1:0][PREG_W-1:0] ld_pd,
  input  logic [NUM_LD-1:0][ROB_W-1:0]  ld_rob,
  output logic                          ld_free,
  output logic [$clog2(NUM_LD)-1:0]     ld_free_idx,
  input  logic                          st_valid,
  input  logic [ROB_W-1:0]              st_rob,
  input  logic [31:0]                   st_addr,
  input  logic [2:0]                    st_f3,
  input  logic [31:0]                   st_data,
  output logic                          st_pop,
  output logic [31:0]                   dc_addr,
  output logic [3:0]                    dc_rmask,
  output logic [3:0]                    dc_wmask,
  output logic [31:0]                   dc_wdata,
  input  logic [31:0]                   dc_rdata,
  input  logic                          dc_resp,
  output logic                          cdb_valid,
  output logic [PREG_W-1:0]             cdb_pd,
  output logic [ROB_W-1:0]              cdb_rob,
  output logic [31:0]                   cdb_data
`ifdef LSU_ISSUE_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_ld,
  output logic [31:0]                   perf_st,
  output logic [31:0]                   perf_flushed
`endif
);

  localparam int IDX_W = $clog2(NUM_LD);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr;
  logic [3:0]          starve_cnt;

  logic                op_ld;
  logic [31:0]         op_addr;
  logic [2:0]          op_f3;
  logic [31:0]         op_data;
  logic [IDX_W-1:0]    op_idx;
  logic [PREG_W-1:0]   op_pd;
  logic [ROB_W-1:0]    op_rob;

  logic                ld_found;
  logic [IDX_W-1:0]    ld_sel;
  logic [IDX_W-1:0]    scan_idx;
  logic                st_elig;
  logic                pick_load;
  logic                issue_ld;
  logic                issue_st;
  logic                active;
  logic [3:0]          lane_mask;
  logic [31:0]         lane;
  logic [31:0]         ld_val;

  // Circular first-ready scan starting at rr_ptr.
  always_comb begin
    ld_found = 1'b0;
    ld_sel   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      scan_idx = rr_ptr + IDX_W'(i);
      if (!ld_found && ld_rdy[scan_idx]) begin
        ld_found = 1'b1;
        ld_sel   = scan_idx;
      end
    end
  end

  assign st_elig   = st_valid && (st_rob == rob_head);
  assign pick_load = ld_found && (!st_elig || (starve_cnt == 4'(STARVE_MAX)));
  assign issue_ld  = (state_q == IDLE) && !flush && pick_load;
  assign issue_st  = (state_q == IDLE) && !flush && st_elig && !pick_load;
  assign active    = (state_q == BUSY) || (state_q == DRAIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and completion strobes; a response taken under flush is dropped.
  always_comb begin
    state_d   = state_q;
    cdb_valid = 1'b0;
    ld_free   = 1'b0;
    st_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_ld || issue_st) state_d = BUSY;
      end
      BUSY: begin
        if (dc_resp) begin
          state_d = IDLE;
          if (!flush) begin
            cdb_valid = 1'b1;
            ld_free   = op_ld;
            st_pop    = !op_ld;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dc_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pointer and store-starvation counter.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (issue_ld) begin
      rr_ptr     <= ld_sel + IDX_W'(1);
      starve_cnt <= '0;
    end else if (issue_st && ld_found && (starve_cnt != 4'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Latch the issued operation so the D-cache request is stable until its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_ld   <= 1'b0;
      op_addr <= '0;
      op_f3   <= '0;
      op_data <= '0;
      op_idx  <= '0;
      op_pd   <= '0;
      op_rob  <= '0;
    end else if (issue_ld || issue_st) begin
      op_ld   <= issue_ld;
      op_addr <= issue_ld ? ld_addr[ld_sel] : st_addr;
      op_f3   <= issue_ld ? ld_f3[ld_sel]   : st_f3;
      op_data <= issue_ld ? 32'd0           : st_data;
      op_idx  <= ld_sel;
      op_pd   <= issue_ld ? ld_pd[ld_sel]   : '0;
      op_rob  <= issue_ld ? ld_rob[ld_sel]  : st_rob;
    end
  end

  // Byte-lane mask from access size and low address bits (misalignment passes through).
  always_comb begin
    case (op_f3[1:0])
      2'b00:   lane_mask = 4'b0001 << op_addr[1:0];
      2'b01:   lane_mask = 4'b0011 << op_addr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  // Extract and extend load data from its lane.
  always_comb begin
    lane = dc_rdata >> {op_addr[1:0], 3'b000};
    case (op_f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'd0, lane[7:0]};
      3'b101:  ld_val = {16'd0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  assign dc_addr     = active ? {op_addr[31:2], 2'b00} : 32'd0;
  assign dc_rmask    = (active && op_ld)  ? lane_mask : 4'd0;
  assign dc_wmask    = (active && !op_ld) ? lane_mask : 4'd0;
  assign dc_wdata    = (active && !op_ld) ? (op_data << {op_addr[1:0], 3'b000}) : 32'd0;
  assign cdb_pd      = ld_free ? op_pd : '0;
  assign cdb_rob     = cdb_valid ? op_rob : '0;
  assign cdb_data    = ld_free ? ld_val : 32'd0;
  assign ld_free_idx = ld_free ? op_idx : '0;

`ifdef LSU_ISSUE_ARB_PERF_EN
  logic resp_discard;
  assign resp_discard = dc_resp && ((state_q == DRAIN) || ((state_q == BUSY) && flush));

  // Completion and discarded-response counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld      <= '0;
      perf_st      <= '0;
      perf_flushed <= '0;
    end else begin
      if (ld_free)      perf_ld      <= perf_ld + 32'd1;
      if (st_pop)       perf_st      <= perf_st + 32'd1;
      if (resp_discard) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_issue_arb.sv
// tb/tb_lsu_issue_arb.sv - randomized and directed bench for lsu_issue_arb against a behavioural model
module tb_lsu_issue_arb;

  localparam int NUM_LD     = 8;
  localparam int ROB_W      = 5;
  localparam int PREG_W     = 6;
  localparam int STARVE_MAX = 4;

  logic                          clk = 1'b0;
  logic                          rst, flush;
  logic [ROB_W-1:0]              rob_head;
  logic [NUM_LD-1:0]             ld_rdy;
  logic [NUM_LD-1:0][31:0]       ld_addr;
  logic [NUM_LD-1:0][2:0]        ld_f3;
  logic [NUM_LD-1:0][PREG_W-1:0] ld_pd;
  logic [NUM_LD-1:0][ROB_W-1:0]  ld_rob;
  logic                          ld_free;
  logic [2:0]                    ld_free_idx;
  logic                          st_valid;
  logic [ROB_W-1:0]              st_rob;
  logic [31:0]                   st_addr;
  logic [2:0]                    st_f3;
  logic [31:0]                   st_data;
  logic                          st_pop;
  logic [31:0]                   dc_addr, dc_wdata, dc_rdata;
  logic [3:0]                    dc_rmask, dc_wmask;
  logic                          dc_resp;
  logic                          cdb_valid;
  logic [PREG_W-1:0]             cdb_pd;
  logic [ROB_W-1:0]              cdb_rob;
  logic [31:0]                   cdb_data;
`ifdef LSU_ISSUE_ARB_PERF_EN
  logic [31:0]                   perf_ld, perf_st, perf_flushed;
`endif

  lsu_issue_arb #(
    .NUM_LD(NUM_LD), .ROB_W(ROB_W), .PREG_W(PREG_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .ld_rdy(ld_rdy), .ld_addr(ld_addr), .ld_f3(ld_f3), .ld_pd(ld_pd), .ld_rob(ld_rob),
    .ld_free(ld_free), .ld_free_idx(ld_free_idx),
    .st_valid(st_valid), .st_rob(st_rob), .st_addr(st_addr), .st_f3(st_f3), .st_data(st_data),
    .st_pop(st_pop),
    .dc_addr(dc_addr), .dc_rmask(dc_rmask), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data)
`ifdef LSU_ISSUE_ARB_PERF_EN
    , .perf_ld(perf_ld), .perf_st(perf_st), .perf_flushed(perf_flushed)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: at most one outstanding operation
  bit          m_busy, m_drain, m_ld;
  logic [31:0] m_addr, m_data;
  logic [2:0]  m_f3;
  int          m_idx, m_rr, m_starve;
  logic [5:0]  m_pd;
  logic [4:0]  m_rob;
  int unsigned m_pld, m_pst, m_pfl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_ld = 0; m_addr = 0; m_data = 0; m_f3 = 0;
    m_idx = 0; m_rr = 0; m_starve = 0; m_pd = 0; m_rob = 0;
    m_pld = 0; m_pst = 0; m_pfl = 0;
  endtask

  task automatic clear_inputs();
    rst = 0; flush = 0; rob_head = 0; ld_rdy = 0; ld_addr = '0; ld_f3 = '0;
    ld_pd = '0; ld_rob = '0; st_valid = 0; st_rob = 0; st_addr = 0; st_f3 = 0;
    st_data = 0; dc_rdata = 0; dc_resp = 0;
  endtask

  // Compare outputs with the model for the current inputs, advance the model, step one clock.
  task automatic cycle();
    bit          act, done, st_ok;
    int          off, sel, v, j;
    logic [3:0]  mask;
    logic [31:0] b, e_cdata;
    #1;
    act = m_busy || m_drain;
    off = int'(m_addr % 4);
    case (m_f3 % 4)
      0:       mask = 4'(1 << off);
      1:       mask = 4'(3 << off);
      default: mask = 4'hF;
    endcase
    done = m_busy && dc_resp && !flush;
    b = dc_rdata >> (8 * off);
    case (m_f3)
      3'd0: begin v = int'(b % 256);   if (v >= 128)   v -= 256;   e_cdata = 32'(v); end
      3'd1: begin v = int'(b % 65536); if (v >= 32768) v -= 65536; e_cdata = 32'(v); end
      3'd4: e_cdata = b % 256;
      3'd5: e_cdata = b % 65536;
      default: e_cdata = b;
    endcase
    chk("dc_addr",   dc_addr,   act ? m_addr - 32'(off) : 32'd0);
    chk("dc_rmask",  32'(dc_rmask), (act && m_ld)  ? 32'(mask) : 32'd0);
    chk("dc_wmask",  32'(dc_wmask), (act && !m_ld) ? 32'(mask) : 32'd0);
    chk("dc_wdata",  dc_wdata,  (act && !m_ld) ? 32'(m_data << (8 * off)) : 32'd0);
    chk("cdb_valid", 32'(cdb_valid), 32'(done));
    chk("ld_free",   32'(ld_free),   32'(done && m_ld));
    chk("st_pop",    32'(st_pop),    32'(done && !m_ld));
    chk("ld_free_idx", 32'(ld_free_idx), (done && m_ld) ? 32'(m_idx) : 32'd0);
    chk("cdb_pd",    32'(cdb_pd),    (done && m_ld) ? 32'(m_pd) : 32'd0);
    chk("cdb_rob",   32'(cdb_rob),   done ? 32'(m_rob) : 32'd0);
    chk("cdb_data",  cdb_data,  (done && m_ld) ? e_cdata : 32'd0);
`ifdef LSU_ISSUE_ARB_PERF_EN
    chk("perf_ld", perf_ld, m_pld);
    chk("perf_st", perf_st, m_pst);
    chk("perf_flushed", perf_flushed, m_pfl);
`endif
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (dc_resp) begin
          m_busy = 0;
          if (flush) m_pfl++;
          else if (m_ld) m_pld++;
          else m_pst++;
        end else if (flush) begin
          m_busy = 0; m_drain = 1;
        end
      end else if (m_drain) begin
        if (dc_resp) begin m_drain = 0; m_pfl++; end
      end else if (!flush) begin
        sel = -1;
        for (int i = 0; i < NUM_LD; i++) begin
          j = (m_rr + i) % NUM_LD;
          if (sel < 0 && ld_rdy[j]) sel = j;
        end
        st_ok = st_valid && (st_rob == rob_head);
        if (sel >= 0 && (!st_ok || m_starve == STARVE_MAX)) begin
          m_busy = 1; m_ld = 1; m_addr = ld_addr[sel]; m_f3 = ld_f3[sel]; m_data = 0;
          m_idx = sel; m_pd = ld_pd[sel]; m_rob = ld_rob[sel];
          m_rr = (sel + 1) % NUM_LD; m_starve = 0;
        end else if (st_ok) begin
          m_busy = 1; m_ld = 0; m_addr = st_addr; m_f3 = st_f3; m_data = st_data;
          m_pd = 0; m_rob = st_rob;
          if (sel >= 0 && m_starve < STARVE_MAX) m_starve++;
        end
      end
      if (flush) begin m_rr = 0; m_starve = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    rst      = ($urandom_range(0, 99) == 0);
    flush    = ($urandom_range(0, 11) == 0);
    rob_head = 5'($urandom);
    st_valid = 1'($urandom_range(0, 1));
    st_rob   = ($urandom_range(0, 3) != 0) ? rob_head : 5'($urandom);
    st_addr  = $urandom;
    st_f3    = 3'($urandom_range(0, 2));
    st_data  = $urandom;
    ld_rdy   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom & $urandom);
    for (int i = 0; i < NUM_LD; i++) begin
      ld_addr[i] = $urandom;
      case ($urandom_range(0, 4))
        0: ld_f3[i] = 3'd0;
        1: ld_f3[i] = 3'd1;
        2: ld_f3[i] = 3'd2;
        3: ld_f3[i] = 3'd4;
        default: ld_f3[i] = 3'd5;
      endcase
      ld_pd[i]  = 6'($urandom);
      ld_rob[i] = 5'($urandom);
    end
    dc_resp  = ($urandom_range(0, 2) == 0);
    dc_rdata = $urandom;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_rmask", 32'(dc_rmask), 32'd0);
    chk("rst_wmask", 32'(dc_wmask), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    rst = 0;

    // round-robin order: rr_ptr 3, ready {5,2} -> 5 then 2, pointer back to 3
    flush = 1; cycle(); flush = 0;
    ld_rdy = 8'b0000_0100; cycle();
    ld_rdy = 0; dc_resp = 1; cycle(); dc_resp = 0;
    ld_rdy = 8'b0010_0100; cycle();
    dc_resp = 1; #1; chk("s035_first", 32'(ld_free_idx), 32'd5); cycle(); dc_resp = 0;
    cycle();
    dc_resp = 1; #1; chk("s035_second", 32'(ld_free_idx), 32'd2); cycle(); dc_resp = 0;
    ld_rdy = 8'hFF; cycle(); ld_rdy = 0;
    dc_resp = 1; #1; chk("s035_rr", 32'(ld_free_idx), 32'd3); cycle(); dc_resp = 0;

    // byte load at 0x1003, signed then unsigned
    ld_addr[1] = 32'h1003; ld_f3[1] = 3'd0; ld_pd[1] = 6'd9; ld_rob[1] = 5'd3;
    ld_rdy = 8'b10; cycle(); ld_rdy = 0;
    chk("s036_rmask", 32'(dc_rmask), 32'h8);
    chk("s036_addr", dc_addr, 32'h1000);
    dc_rdata = 32'h80123456; dc_resp = 1; #1;
    chk("s036_lb", cdb_data, 32'hFFFFFF80); cycle(); dc_resp = 0;
    ld_f3[1] = 3'd4; ld_rdy = 8'b10; cycle(); ld_rdy = 0;
    dc_resp = 1; #1; chk("s036_lbu", cdb_data, 32'h00000080); cycle(); dc_resp = 0;

    // starvation: four stores, then the waiting load, then a store
    flush = 1; cycle(); flush = 0;
    st_valid = 1; st_rob = 0; rob_head = 0; st_f3 = 3'd2; st_addr = 32'h40; st_data = 32'h11;
    ld_addr[0] = 32'h80; ld_f3[0] = 3'd2; ld_rdy = 8'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      dc_resp = 1; #1;
      chk("s037_pop", 32'(st_pop), 32'(k != 4));
      chk("s037_free", 32'(ld_free), 32'(k == 4));
      cycle(); dc_resp = 0;
    end
    ld_rdy = 0;

    // halfword store at 0x2002
    st_addr = 32'h2002; st_f3 = 3'd1; st_data = 32'h1234BEEF; cycle();
    st_valid = 0;
    chk("s038_wmask", 32'(dc_wmask), 32'hC);
    chk("s038_wdata_hi", 32'(dc_wdata[31:16]), 32'hBEEF);
    dc_resp = 1; #1; chk("s038_pop", 32'(st_pop), 32'd1); cycle(); dc_resp = 0;

    // flush one cycle after a load issue; response discarded in DRAIN
    ld_rdy = 8'b1; cycle(); ld_rdy = 0;
    flush = 1; cycle(); flush = 0;
    cycle(); cycle();
    dc_resp = 1; #1;
    chk("s039_cdb", 32'(cdb_valid), 32'd0);
    chk("s039_free", 32'(ld_free), 32'd0);
    cycle(); dc_resp = 0;
    chk("s039_idle", 32'(dc_rmask), 32'd0);
`ifdef LSU_ISSUE_ARB_PERF_EN
    chk("s039_perf_flushed", perf_flushed, 32'd1);
`endif

    // reset while busy; later response is ignored
    ld_rdy = 8'b1; cycle(); ld_rdy = 0;
    rst = 1; cycle(); rst = 0;
    chk("s040_rmask", 32'(dc_rmask), 32'd0);
    chk("s040_addr", dc_addr, 32'd0);
    dc_resp = 1; #1; chk("s040_cdb", 32'(cdb_valid), 32'd0); cycle(); dc_resp = 0;

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
